// File: rtl/uart_tx_sched.sv
// Transmit scheduler: round-robin arbitration of two byte producers into a ring
// buffer, with an FSM that drives the uart_tx start/busy handshake and retries.
module uart_tx_sched #(
    parameter int DEPTH_LOG2  = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [7:0]            req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [7:0]            req1_data,
    output logic                  req1_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  idle,
    output logic [15:0]           sent_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_ACK,
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_last;
    logic [TO_W-1:0]       r_to_cnt;
    logic [7:0]            r_tx_data;
    logic [15:0]           r_sent_cnt;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_push;
    logic [7:0]            w_push_data;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_to_inc;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // r_last names the port granted most recently; a tie goes to the other one.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!w_full) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = r_last;
                w_gnt1 = !r_last;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign w_push      = w_gnt0 | w_gnt1;
    assign w_push_data = w_gnt1 ? req1_data : req0_data;

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_to_inc = 1'b0;
        w_pop    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !tx_busy) begin
                    w_next = S_LAUNCH;
                    w_load = 1'b1;
                end
            end
            S_LAUNCH: w_next = S_ACK;
            S_ACK: begin
                if (tx_busy) begin
                    w_next = S_DRAIN;
                end else if (r_to_cnt == TO_LAST) begin
                    w_next = S_LAUNCH;
                end else begin
                    w_to_inc = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!tx_busy) begin
                    w_pop  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Timeout counter only runs while waiting in ACK; it idles at zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_to_inc) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last     <= 1'b1;
            r_tx_data  <= 8'h00;
            r_sent_cnt <= 16'h0000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
                r_last   <= w_gnt1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + DEPTH_LOG2'(1);
                r_sent_cnt <= r_sent_cnt + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_load) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

    // Buffer storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign tx_data    = r_tx_data;
    assign tx_start   = (r_state == S_LAUNCH);
    assign count      = r_count;
    assign empty      = w_empty;
    assign full       = w_full;
    assign idle       = w_empty && (r_state == S_IDLE);
    assign sent_cnt   = r_sent_cnt;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a small uart_tx busy model.
`timescale 1ns/1ps
module tb_uart_tx_sched;
    localparam int DL2      = 2;
    localparam int ATO      = 4;
    localparam int BUSY_LEN = 20;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid;
    logic [7:0]     req0_data;
    logic           req0_ready;
    logic           req1_valid;
    logic [7:0]     req1_data;
    logic           req1_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic [DL2:0]   count;
    logic           empty;
    logic           full;
    logic           idle;
    logic [15:0]    sent_cnt;

    uart_tx_sched #(.DEPTH_LOG2(DL2), .ACK_TIMEOUT(ATO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .count(count), .empty(empty), .full(full), .idle(idle), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    // uart_tx model: busy rises after a sampled start and stays up BUSY_LEN cycles
    int         busy_rem   = 0;
    logic       busy_force = 1'b0;
    logic       ack_en     = 1'b1;
    int         cyc        = 0;
    logic [7:0] log_q[$];
    int         start_cyc[$];
    logic [7:0] exp_q[$];

    assign tx_busy = busy_force | (busy_rem != 0);

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            busy_rem = 0;
        end else begin
            if (busy_rem != 0) busy_rem = busy_rem - 1;
            if (tx_start) begin
                log_q.push_back(tx_data);
                start_cyc.push_back(cyc);
                if (ack_en) busy_rem = BUSY_LEN;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input bit ch, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        if (ch) begin req1_valid = 1'b1; req1_data = d; end
        else    begin req0_valid = 1'b1; req0_data = d; end
        for (int i = 0; i < 400 && !ok; i++) begin
            #1;
            ok = ch ? req1_ready : req0_ready;
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("push_accepted", {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (idle) done = 1'b1;
            else @(negedge clk);
        end
        chk("idle_reached", {31'b0, done}, 32'd1);
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(nm, (i < log_q.size()) ? {24'b0, log_q[i]} : 32'hFFFF_FFFF, {24'b0, exp_q[i]});
        end
    endtask

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       er0;
        logic       er1;
        int         ecnt;
        logic       efull;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int i0, i1, prev_c, viol;
        bit g0, g1, got, seen;
        logic [15:0] exp_sent;

        vecs[0] = '{1'b1, 8'hC0, 1'b1, 8'hD0, 1'b1, 1'b0, 1, 1'b0};
        vecs[1] = '{1'b0, 8'hC1, 1'b0, 8'hD1, 1'b0, 1'b0, 1, 1'b0};
        vecs[2] = '{1'b1, 8'hC2, 1'b1, 8'hD2, 1'b0, 1'b1, 2, 1'b0};
        vecs[3] = '{1'b1, 8'hC3, 1'b0, 8'hD3, 1'b1, 1'b0, 3, 1'b0};
        vecs[4] = '{1'b1, 8'hC4, 1'b1, 8'hD4, 1'b0, 1'b1, 4, 1'b1};
        vecs[5] = '{1'b1, 8'hC5, 1'b1, 8'hD5, 1'b0, 1'b0, 4, 1'b1};
        vecs[6] = '{1'b0, 8'hC6, 1'b1, 8'hD6, 1'b0, 1'b0, 4, 1'b1};

        rst = 1'b1;
        req0_valid = 1'b0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", {29'b0, count}, 32'd0);
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_idle", {31'b0, idle}, 32'd1);
        chk("rst_tx_start", {31'b0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
        chk("rst_sent_cnt", {16'b0, sent_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single byte and launch latency
        req1_valid = 1'b1; req1_data = 8'h41;
        #1;
        chk("single_ready1", {31'b0, req1_ready}, 32'd1);
        chk("single_ready0", {31'b0, req0_ready}, 32'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        chk("single_count_n1", {29'b0, count}, 32'd1);
        chk("single_start_n1", {31'b0, tx_start}, 32'd0);
        @(negedge clk);
        chk("single_start_n2", {31'b0, tx_start}, 32'd1);
        chk("single_data_n2", {24'b0, tx_data}, 32'h41);
        wait_idle();
        exp_sent = 16'd1;
        exp_q.delete(); exp_q.push_back(8'h41);
        check_log("single_log");
        chk("single_sent_cnt", {16'b0, sent_cnt}, {16'b0, exp_sent});

        // arbitration and full table, transmitter held busy
        log_q.delete(); exp_q.delete();
        busy_force = 1'b1;
        for (int k = 0; k < 7; k++) begin
            req0_valid = vecs[k].v0; req0_data = vecs[k].d0;
            req1_valid = vecs[k].v1; req1_data = vecs[k].d1;
            #1;
            chk($sformatf("vec%0d_ready0", k), {31'b0, req0_ready}, {31'b0, vecs[k].er0});
            chk($sformatf("vec%0d_ready1", k), {31'b0, req1_ready}, {31'b0, vecs[k].er1});
            if (vecs[k].er0) exp_q.push_back(vecs[k].d0);
            if (vecs[k].er1) exp_q.push_back(vecs[k].d1);
            @(negedge clk);
            chk($sformatf("vec%0d_count", k), {29'b0, count}, vecs[k].ecnt);
            chk($sformatf("vec%0d_full", k), {31'b0, full}, {31'b0, vecs[k].efull});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("busy_no_launch", log_q.size(), 32'd0);
        busy_force = 1'b0;
        wait_idle();
        exp_sent = exp_sent + 16'd4;
        check_log("table_log");
        chk("table_sent_cnt", {16'b0, sent_cnt}, {16'b0, exp_sent});

        // contention: both channels valid every cycle
        log_q.delete(); exp_q.delete();
        i0 = 0; i1 = 0;
        for (int c = 0; c < 2000 && (i0 < 4 || i1 < 4); c++) begin
            req0_valid = (i0 < 4); req0_data = 8'hA0 + 8'(i0);
            req1_valid = (i1 < 4); req1_data = 8'h10 + 8'(i1);
            #1;
            g0 = req0_ready; g1 = req1_ready;
            @(negedge clk);
            if (g0) i0++;
            if (g1) i1++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("contend_all_pushed", i0 + i1, 32'd8);
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(8'hA0 + 8'(k));
            exp_q.push_back(8'h10 + 8'(k));
        end
        exp_sent = exp_sent + 16'd8;
        check_log("contend_log");
        chk("contend_sent_cnt", {16'b0, sent_cnt}, {16'b0, exp_sent});

        // push coinciding with a pop while full
        log_q.delete(); exp_q.delete();
        busy_force = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(1'b0, 8'h31 + 8'(k));
            exp_q.push_back(8'h31 + 8'(k));
        end
        chk("pp_full", {31'b0, full}, 32'd1);
        req0_valid = 1'b1; req0_data = 8'h77;
        busy_force = 1'b0;
        prev_c = 4; viol = 0; got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            #1;
            if (req0_ready) begin
                got = 1'b1;
                chk("pp_accept_count", {29'b0, count}, 32'd3);
                chk("pp_prev_count", prev_c, 32'd4);
            end else begin
                if (count != 3'd4) viol++;
                prev_c = count;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        chk("pp_accepted", {31'b0, got}, 32'd1);
        chk("pp_ready_while_full", viol, 32'd0);
        chk("pp_count_after", {29'b0, count}, 32'd4);
        exp_q.push_back(8'h77);
        wait_idle();
        exp_sent = exp_sent + 16'd5;
        check_log("pp_log");
        chk("pp_sent_cnt", {16'b0, sent_cnt}, {16'b0, exp_sent});

        // retry on missing acknowledge
        log_q.delete(); start_cyc.delete();
        ack_en = 1'b0;
        push(1'b1, 8'h5A);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (start_cyc.size() >= 3) seen = 1'b1;
            else @(negedge clk);
        end
        chk("to_three_starts", {31'b0, seen}, 32'd1);
        if (seen) begin
            chk("to_period1", start_cyc[1] - start_cyc[0], ATO + 1);
            chk("to_period2", start_cyc[2] - start_cyc[1], ATO + 1);
            chk("to_data0", {24'b0, log_q[0]}, 32'h5A);
            chk("to_data2", {24'b0, log_q[2]}, 32'h5A);
        end
        chk("to_no_pop_count", {29'b0, count}, 32'd1);
        chk("to_no_pop_sent", {16'b0, sent_cnt}, {16'b0, exp_sent});
        ack_en = 1'b1;
        wait_idle();
        exp_sent = exp_sent + 16'd1;
        chk("to_sent_cnt", {16'b0, sent_cnt}, {16'b0, exp_sent});

        // reset while draining with three bytes buffered
        log_q.delete();
        busy_force = 1'b1;
        push(1'b0, 8'h61);
        push(1'b0, 8'h62);
        push(1'b0, 8'h63);
        chk("rd_count3", {29'b0, count}, 32'd3);
        busy_force = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (log_q.size() >= 1) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rd_launched", {31'b0, seen}, 32'd1);
        repeat (3) @(negedge clk);
        chk("rd_drain_data", {24'b0, tx_data}, 32'h61);
        rst = 1'b1;
        #1;
        chk("rd_count0", {29'b0, count}, 32'd0);
        chk("rd_tx_start", {31'b0, tx_start}, 32'd0);
        chk("rd_tx_data", {24'b0, tx_data}, 32'd0);
        chk("rd_idle", {31'b0, idle}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        log_q.delete(); exp_q.delete();
        @(negedge clk);
        chk("rd_sent_cnt0", {16'b0, sent_cnt}, 32'd0);
        push(1'b1, 8'h55);
        wait_idle();
        exp_q.push_back(8'h55);
        check_log("rd_log");
        chk("rd_sent_cnt1", {16'b0, sent_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
